// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the buffered UART transmitter.
//   uart_tx_state_e  : serializer FSM states (PARITY is only reachable when the
//                      UART_TX_PARITY_EN build macro is defined)
//   cycles_per_bit() : clock cycles per bit period (integer division)
//   UART_IDLE_LEVEL  : line level while no frame is being sent
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PARITY
    } uart_tx_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic int cycles_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through read data.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (flushes the queue)
//   push_i, data_i    write request and data; ignored while full
//   pop_i, data_o     read request; data_o always shows the head entry
//   full_o, empty_o   occupancy flags
//   level_o           number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap for free.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         pop_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Fullness is judged on the current count only, so a pop in the same
    // cycle never makes room for a push while full.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and level define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_tx_queue
// Buffered UART transmitter: bytes written over a valid/ready port are queued
// in a QUEUE_LEN-entry FIFO and serialized LSB first onto tx_o as 8N1 frames.
// Back-to-back frames are contiguous (stop bit end pops straight into START).
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (aborts any frame)
//   valid_i/data_i write request; accepted on an edge where valid_i && ready_o
//   ready_o        FIFO not full
//   busy_o         FIFO non-empty or frame in progress
//   level_o        FIFO occupancy, excluding the byte being shifted out
//   tx_o           registered serial line, idle high
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the last data bit and the stop bit.
// ---------------------------------------------------------------------------
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int QUEUE_LEN  = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             valid_i,
    input  logic [DATA_WIDTH-1:0]            data_i,
    output logic                             ready_o,
    output logic                             busy_o,
    output logic [$clog2(QUEUE_LEN+1)-1:0]   level_o,
    output logic                             tx_o
);

    localparam int CPB   = cycles_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPB - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_WIDTH - 1);

    if (CPB < 2) begin : g_cpb_check
        $error("uart_tx_queue: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if ((QUEUE_LEN < 2) || ((QUEUE_LEN & (QUEUE_LEN - 1)) != 0)) begin : g_len_check
        $error("uart_tx_queue: QUEUE_LEN must be a power of two >= 2");
    end

    uart_tx_state_e        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  load_frame;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (QUEUE_LEN)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (valid_i),
        .data_i  (data_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign ready_o = !fifo_full;
    assign busy_o  = (state_q != IDLE) || !fifo_empty;
    assign tx_o    = tx_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        load_frame = 1'b0;
        fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                tx_d       = UART_IDLE_LEVEL;
                load_frame = !fifo_empty;
            end
            START: begin
                if (cnt_q == '0) begin
                    state_d = DATA;
                    cnt_d   = CNT_MAX;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_MAX;
                    if (idx_q == IDX_MAX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = UART_IDLE_LEVEL;
`endif
                    end else begin
                        // Shift first, then drive the new LSB.
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    state_d = STOP;
                    cnt_d   = CNT_MAX;
                    tx_d    = UART_IDLE_LEVEL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == '0) begin
                    // Queued data chains straight into the next start bit.
                    state_d    = IDLE;
                    tx_d       = UART_IDLE_LEVEL;
                    load_frame = !fifo_empty;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = UART_IDLE_LEVEL;
            end
        endcase

        if (load_frame) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            state_d  = START;
            cnt_d    = CNT_MAX;
            tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_head;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
